tx_dac_snapshot: RTL and testbench

- Downstream neighbour of the TX core. Registers the 8-lane DAC sample word through to the DAC.
- On command, captures a triggered snapshot of 2**DEPTH_LOG2 consecutive DAC words into block RAM.
- Streams the captured samples out, one 16-bit sample per beat, over a valid/ready interface for a debug DMA path.

---
 rtl/tx_dac_snapshot_pkg.sv | 19 +
 rtl/tx_dac_snapshot_if.sv | 18 +
 rtl/tx_dac_snapshot_ram.sv | 31 +++
 rtl/tx_dac_snapshot.sv | 209 ++++++++++++++++++++
 tb/tb_tx_dac_snapshot.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_dac_snapshot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tx_snapshot_pkg
//  Purpose  : Shared types and constants for the TX DAC snapshot block.
//  Revision : 1.0  initial release
// ============================================================================
package tx_snapshot_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tx_dac_snapshot_if.sv
`default_nettype none
// ============================================================================
//  Module   : tx_dac_snapshot_if
//  Purpose  : Valid/ready sample stream carrying snapshot readout beats.
//  Revision : 1.0  initial release
// ============================================================================
interface tx_dac_snapshot_if;
  import tx_snapshot_pkg::*;

  logic [SAMPLE_WIDTH-1:0] m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface
`default_nettype wire

// File: rtl/tx_dac_snapshot_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tx_snapshot_ram
//  Purpose  : Simple dual-port RAM, one write port and one registered read
//             port (1-cycle latency), shaped for block RAM inference.
//  Revision : 1.0  initial release
// ============================================================================
module tx_snapshot_ram #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 10
) (
  input  wire logic              clock,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [WIDTH-1:0]  wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write port plus registered read; no reset so the array maps to block RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/tx_dac_snapshot.sv
`default_nettype none
// ============================================================================
//  Module   : tx_dac_snapshot
//  Purpose  : Registers the DAC word through to the DAC and, on command,
//             captures 2**DEPTH_LOG2 consecutive words, then streams them out
//             one 16-bit sample per beat.
//  Revision : 1.0  initial release
// ============================================================================
module tx_dac_snapshot
  import tx_snapshot_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int DEPTH_LOG2     = 10
) (
  input  wire logic                                   clock,
  input  wire logic                                   resetn,
  input  wire logic [SAMPLE_WIDTH*NUMBER_OF_LINE-1:0] dac_data_in,
  output logic      [SAMPLE_WIDTH*NUMBER_OF_LINE-1:0] dac_data,
  input  wire logic                                   arm,
  input  wire logic                                   trigger,
  input  wire logic                                   abort,
  tx_dac_snapshot_if.master                           m_axis,
  output logic                                        busy,
  output logic                                        done
);

  localparam int WORD_W = SAMPLE_WIDTH * NUMBER_OF_LINE;
  localparam int LANE_W = $clog2(NUMBER_OF_LINE);
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(NUMBER_OF_LINE - 1);
  localparam logic [DEPTH_LOG2-1:0] LAST_WORD = {DEPTH_LOG2{1'b1}};

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DEPTH_LOG2-1:0] waddr_q, waddr_d;
  logic [DEPTH_LOG2-1:0] raddr_q, raddr_d;
  logic                  rd_all_q, rd_all_d;    // every word has been requested
  logic                  rd_pend_q, rd_pend_d;  // RAM output holds a requested word
  logic [WORD_W-1:0]     word_q, word_d;        // word currently being emitted
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DEPTH_LOG2-1:0] oword_q, oword_d;      // index of the emitted word
  logic                  valid_q, valid_d;
  logic [WORD_W-1:0]     pf_q, pf_d;            // prefetched next word
  logic                  pf_valid_q, pf_valid_d;
  logic [WORD_W-1:0]     dac_data_q;

  logic                  ram_we;
  logic [WORD_W-1:0]     ram_rdata;
  logic                  fire;
  logic                  last_lane;
  logic                  word_done;

  tx_snapshot_ram #(
    .WIDTH  (WORD_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (waddr_q),
    .wdata (dac_data_in),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

  assign fire      = valid_q & m_axis.m_tready;
  assign last_lane = (lane_q == LAST_LANE);
  assign word_done = fire & last_lane;

  // DAC passthrough, independent of the capture machinery.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) dac_data_q <= '0;
    else         dac_data_q <= dac_data_in;
  end

  // Next-state logic: capture sequencing and the two-deep readout buffer
  // (output word + prefetch) that hides the RAM read latency.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    rd_all_d   = rd_all_q;
    rd_pend_d  = 1'b0;
    word_d     = word_q;
    lane_d     = lane_q;
    oword_d    = oword_q;
    valid_d    = valid_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    ram_we     = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      waddr_d    = '0;
      raddr_d    = '0;
      rd_all_d   = 1'b0;
      lane_d     = '0;
      oword_d    = '0;
      valid_d    = 1'b0;
      pf_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d = ARMED;
            done_d  = 1'b0;
          end
        end
        ARMED: begin
          if (trigger) begin
            ram_we  = 1'b1;
            waddr_d = waddr_q + 1'b1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          ram_we  = 1'b1;
          waddr_d = waddr_q + 1'b1;  // wraps to 0 after the last word
          if (waddr_q == LAST_WORD) state_d = READOUT;
        end
        READOUT: begin
          if (fire && !last_lane) lane_d = lane_q + 1'b1;
          if (word_done) oword_d = oword_q + 1'b1;
          if (word_done && (oword_q == LAST_WORD)) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            valid_d    = 1'b0;
            pf_valid_d = 1'b0;
            raddr_d    = '0;
            rd_all_d   = 1'b0;
            lane_d     = '0;
            oword_d    = '0;
          end else begin
            if (!valid_q || word_done) begin
              // Output slot is free: refill from prefetch first, then RAM.
              if (pf_valid_q) begin
                word_d     = pf_q;
                valid_d    = 1'b1;
                lane_d     = '0;
                pf_valid_d = 1'b0;
              end else if (rd_pend_q) begin
                word_d  = ram_rdata;
                valid_d = 1'b1;
                lane_d  = '0;
              end else begin
                valid_d = 1'b0;
              end
            end else if (rd_pend_q) begin
              pf_d       = ram_rdata;
              pf_valid_d = 1'b1;
            end
            // Request the next word only when nothing is in flight and the
            // prefetch slot is empty, so at most two words are ever held.
            if (!rd_all_q && !rd_pend_q && !pf_valid_q) begin
              rd_pend_d = 1'b1;
              raddr_d   = raddr_q + 1'b1;
              if (raddr_q == LAST_WORD) rd_all_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb busy_d = (state_d != IDLE);

  // Control and readout state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      rd_all_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      word_q     <= '0;
      lane_q     <= '0;
      oword_q    <= '0;
      valid_q    <= 1'b0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      rd_all_q   <= rd_all_d;
      rd_pend_q  <= rd_pend_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      oword_q    <= oword_d;
      valid_q    <= valid_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
    end
  end

  assign dac_data        = dac_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign m_axis.m_tvalid = valid_q;
  assign m_axis.m_tdata  = word_q[SAMPLE_WIDTH*int'(lane_q) +: SAMPLE_WIDTH];
  assign m_axis.m_tlast  = valid_q && last_lane && (oword_q == LAST_WORD);

endmodule
`default_nettype wire

// File: tb/tb_tx_dac_snapshot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_dac_snapshot
//  Purpose  : Self-checking bench for tx_dac_snapshot (DEPTH_LOG2=4, 8 lanes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_dac_snapshot;

  localparam int NL    = 8;
  localparam int DL2   = 4;
  localparam int BEATS = (2**DL2) * NL;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [16*NL-1:0] dac_data_in = '0;
  logic [16*NL-1:0] dac_data;
  logic            arm = 1'b0, trigger = 1'b0, abort = 1'b0;
  logic            busy, done;

  int checks = 0;
  int failures = 0;
  int k = 0;
  bit gen_on = 1'b0;

  tx_dac_snapshot_if axis ();

  tx_dac_snapshot #(
    .NUMBER_OF_LINE (NL),
    .DEPTH_LOG2     (DL2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .dac_data_in (dac_data_in),
    .dac_data    (dac_data),
    .arm         (arm),
    .trigger     (trigger),
    .abort       (abort),
    .m_axis      (axis.master),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             arm;
    logic             trig;
    logic             abort;
    logic [16*NL-1:0] din;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [16*NL-1:0] word_of(input int kk);
    logic [16*NL-1:0] w;
    for (int i = 0; i < NL; i++) w[16*i +: 16] = {kk[7:0], i[7:0]};
    return w;
  endfunction

  task automatic chk(input string name, input logic [16*NL-1:0] act, input logic [16*NL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // One clock: advance to just after the edge, then move the data pattern on.
  task automatic step();
    @(posedge clock);
    #1;
    k++;
    if (gen_on) dac_data_in = word_of(k);
  endtask

  task automatic trig_at(input int kt);
    int guard = 0;
    while (k != kt && guard < 100) begin
      step();
      guard++;
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  // Consume beats until nstop transfers; checks data, last, hold and bubbles.
  task automatic collect(input int start_k, input int nstop, input bit bp);
    int beats = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    bit started = 1'b0;
    logic [15:0] pd = '0;
    logic pl = 1'b0;
    logic rdy;
    logic [15:0] e;
    int wk;
    while (beats < nstop && cyc < 4000) begin
      if (prev_stall) begin
        chk("hold_valid", 128'(axis.m_tvalid), 128'(1));
        chk("hold_data", 128'(axis.m_tdata), 128'(pd));
        chk("hold_last", 128'(axis.m_tlast), 128'(pl));
      end
      if (!bp && started) chk("no_bubble", 128'(axis.m_tvalid), 128'(1));
      rdy = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      axis.m_tready = rdy;
      if (axis.m_tvalid && rdy) begin
        wk = start_k + beats / NL;
        e = {wk[7:0], 8'(beats % NL)};
        chk($sformatf("beat%0d_data", beats), 128'(axis.m_tdata), 128'(e));
        chk($sformatf("beat%0d_last", beats), 128'(axis.m_tlast), 128'(beats == BEATS - 1));
        beats++;
        started = 1'b1;
      end
      prev_stall = axis.m_tvalid && !rdy;
      pd = axis.m_tdata;
      pl = axis.m_tlast;
      step();
      cyc++;
    end
    axis.m_tready = 1'b0;
    if (beats < nstop) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout got=%0d exp=%0d beats", beats, nstop);
    end
  endtask

  task automatic chk_complete(input string tag);
    chk({tag, "_tvalid"}, 128'(axis.m_tvalid), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    axis.m_tready = 1'b0;

    tbl[0] = '{arm:1'b0, trig:1'b1, abort:1'b0, din:128'h0123456789ABCDEF_FEDCBA9876543210, exp_busy:1'b0, exp_done:1'b1};
    tbl[1] = '{arm:1'b1, trig:1'b0, abort:1'b0, din:128'h1111_2222_3333_4444_5555_6666_7777_8888, exp_busy:1'b1, exp_done:1'b0};
    tbl[2] = '{arm:1'b1, trig:1'b1, abort:1'b1, din:128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_0F0F_F0F0, exp_busy:1'b0, exp_done:1'b0};
    tbl[3] = '{arm:1'b0, trig:1'b1, abort:1'b0, din:128'h0, exp_busy:1'b0, exp_done:1'b0};
    tbl[4] = '{arm:1'b1, trig:1'b1, abort:1'b0, din:128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, exp_busy:1'b1, exp_done:1'b0};
    tbl[5] = '{arm:1'b0, trig:1'b0, abort:1'b0, din:128'h8000_0001_8000_0001_8000_0001_8000_0001, exp_busy:1'b1, exp_done:1'b0};
    tbl[6] = '{arm:1'b0, trig:1'b0, abort:1'b0, din:128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, exp_busy:1'b1, exp_done:1'b0};

    // Reset state
    dac_data_in = 128'h0123456789ABCDEF_FEDCBA9876543210;
    repeat (2) step();
    chk("rst_dac_data", dac_data, '0);
    chk("rst_tdata", 128'(axis.m_tdata), '0);
    chk("rst_tvalid", 128'(axis.m_tvalid), '0);
    chk("rst_tlast", 128'(axis.m_tlast), '0);
    chk("rst_busy", 128'(busy), '0);
    chk("rst_done", 128'(done), '0);
    resetn = 1'b1;
    step();
    chk("pass_first", dac_data, 128'h0123456789ABCDEF_FEDCBA9876543210);

    // Basic capture, trigger at k=5
    gen_on = 1'b1;
    k = 0;
    dac_data_in = word_of(0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig_at(5);
    collect(5, BEATS, 1'b0);
    chk_complete("basic");

    // Backpressure, trigger at k=7
    k = 0;
    dac_data_in = word_of(0);
    arm = 1'b1;
    step();
    chk("bp_done_cleared", 128'(done), 128'(0));
    arm = 1'b0;
    trig_at(7);
    collect(7, BEATS, 1'b1);
    chk_complete("bp");

    // Control vectors: trigger in IDLE, abort priority, arm+trigger together
    gen_on = 1'b0;
    for (int r = 0; r < 7; r++) begin
      arm = tbl[r].arm;
      trigger = tbl[r].trig;
      abort = tbl[r].abort;
      dac_data_in = tbl[r].din;
      step();
      chk($sformatf("vec%0d_dac", r), dac_data, tbl[r].din);
      chk($sformatf("vec%0d_busy", r), 128'(busy), 128'(tbl[r].exp_busy));
      chk($sformatf("vec%0d_done", r), 128'(done), 128'(tbl[r].exp_done));
      chk($sformatf("vec%0d_tvalid", r), 128'(axis.m_tvalid), 128'(0));
    end
    arm = 1'b0;
    trigger = 1'b0;
    abort = 1'b0;

    // Still ARMED from the arm+trigger cycle; real trigger at k=9
    gen_on = 1'b1;
    k = 0;
    dac_data_in = word_of(0);
    trig_at(9);
    collect(9, BEATS, 1'b0);
    chk_complete("k9");

    // Abort mid-readout after beat 40, with handshake active
    k = 0;
    dac_data_in = word_of(0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig_at(3);
    collect(3, 41, 1'b0);
    axis.m_tready = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    axis.m_tready = 1'b0;
    chk("abort_tvalid", 128'(axis.m_tvalid), 128'(0));
    chk("abort_tlast", 128'(axis.m_tlast), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    repeat (3) step();
    chk("abort_idle_tvalid", 128'(axis.m_tvalid), 128'(0));

    k = 0;
    dac_data_in = word_of(0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig_at(2);
    collect(2, BEATS, 1'b0);
    chk_complete("rearm");

    // Async reset during CAPTURE
    k = 0;
    dac_data_in = word_of(0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    trig_at(3);
    repeat (4) step();
    chk("cap_busy", 128'(busy), 128'(1));
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_dac_data", dac_data, '0);
    chk("arst_tdata", 128'(axis.m_tdata), '0);
    chk("arst_tvalid", 128'(axis.m_tvalid), '0);
    chk("arst_tlast", 128'(axis.m_tlast), '0);
    chk("arst_busy", 128'(busy), '0);
    chk("arst_done", 128'(done), '0);
    step();
    step();
    resetn = 1'b1;
    trigger = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      chk($sformatf("post_rst_busy%0d", c), 128'(busy), 128'(0));
      chk($sformatf("post_rst_tvalid%0d", c), 128'(axis.m_tvalid), 128'(0));
    end
    trigger = 1'b0;
    chk("post_rst_pass", dac_data, word_of(k - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
